// File: rtl/sdram_pkg.sv
// Shared encodings, widths and wait-count helpers for the SDRAM command generator.
package sdram_pkg;

   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned ROW_W    = 8;
   localparam int unsigned COL_W    = 8;
   localparam int unsigned SDADDR_W = 8;
   localparam int unsigned TIME_W   = 8;
   localparam int unsigned LAT_W    = 4;
   localparam int unsigned CNT_W    = 10;
   localparam int unsigned STATE_W  = 3;

   typedef struct packed {
      logic cs;
      logic ras;
      logic cas;
      logic we;
   } cmd_t;

   localparam cmd_t CMD_NOP       = 4'b1111;
   localparam cmd_t CMD_PRECHARGE = 4'b0010;
   localparam cmd_t CMD_ACTIVATE  = 4'b0011;
   localparam cmd_t CMD_WRITE     = 4'b0100;
   localparam cmd_t CMD_READ      = 4'b0101;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_PRE      = 3'd1,
      ST_PRE_WAIT = 3'd2,
      ST_ACT      = 3'd3,
      ST_ACT_WAIT = 3'd4,
      ST_RW       = 3'd5,
      ST_RW_WAIT  = 3'd6,
      ST_RECOVER  = 3'd7
   } state_t;

   // Counter holds (cycles - 1) so the zero flag marks the last cycle of a wait.
   function automatic logic [CNT_W-1:0] wait_load(input logic [TIME_W-1:0] t);
      return (t == '0) ? '0 : CNT_W'(t) - CNT_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] rw_load(input logic              we,
                                                input logic [LAT_W-1:0]  lat,
                                                input logic [TIME_W-1:0] burst,
                                                input logic [TIME_W-1:0] wt);
      logic [CNT_W-1:0] lat_part;
      logic [CNT_W-1:0] burst_part;
      lat_part   = we ? '0 : CNT_W'(lat);
      burst_part = (burst == '0) ? CNT_W'(1) : CNT_W'(burst);
      return lat_part + burst_part + CNT_W'(wt) - CNT_W'(1);
   endfunction

endpackage

// File: rtl/sdram_wait_counter.sv
// Loadable down-counter with enable and zero flag; provides every wait of the command generator.
module sdram_wait_counter
   import sdram_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             zero_c
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         if (load) begin
            count <= load_value;
         end else if (count != '0) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/sdram_cmd_gen.sv
// SDRAM command sequencer: PRECHARGE / ACTIVATE / READ|WRITE with programmable waits.
// Define SDRAM_OPEN_ROW_EN to keep the last row open and skip PRE/ACT on a row hit.
module sdram_cmd_gen
   import sdram_pkg::*;
(
   input  logic                Clk,
   input  logic                Rst,
   input  logic                En,
   input  logic                ReqValid,
   input  logic                ReqWe,
   input  logic [ADDR_W-1:0]   ReqAddr,
   input  logic [TIME_W-1:0]   tpre,
   input  logic [TIME_W-1:0]   tcas,
   input  logic [TIME_W-1:0]   tburst,
   input  logic [TIME_W-1:0]   twait,
   input  logic [LAT_W-1:0]    tlat,
   output logic                ReqReady,
   output logic                Done,
   output logic                CS,
   output logic                RAS,
   output logic                CAS,
   output logic                WeOut,
   output logic [SDADDR_W-1:0] SdramAddr,
   output logic [STATE_W-1:0]  StateOut
);

   state_t              state_q, state_d;
   cmd_t                cmd_q, cmd_d;
   logic [SDADDR_W-1:0] addr_q, addr_d;
   logic                done_q, done_d;
   logic                ready_q, ready_d;
   logic                accept;
   logic                cnt_load;
   logic [CNT_W-1:0]    cnt_value;
   logic                cnt_zero;
   logic                row_hit;

   logic                we_q;
   logic [ROW_W-1:0]    row_q;
   logic [COL_W-1:0]    col_q;
   logic [ROW_W-1:0]    req_row;
   logic [COL_W-1:0]    req_col;

   assign req_row = ReqAddr[ADDR_W-1 -: ROW_W];
   assign req_col = ReqAddr[COL_W-1:0];

`ifdef SDRAM_OPEN_ROW_EN
   logic [ROW_W-1:0] open_row_q;
   logic             open_valid_q;

   assign row_hit = open_valid_q && (open_row_q == req_row);

   // Row becomes open when ACTIVATE is issued; reset forgets it.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         open_row_q   <= '0;
         open_valid_q <= 1'b0;
      end else if ((state_d == ST_ACT) && (state_q != ST_ACT)) begin
         open_row_q   <= row_q;
         open_valid_q <= 1'b1;
      end
   end
`else
   assign row_hit = 1'b0;
`endif

   sdram_wait_counter u_wait (
      .clk        (Clk),
      .rst        (Rst),
      .en         (En),
      .load       (cnt_load),
      .load_value (cnt_value),
      .zero_c     (cnt_zero)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus the command to register on the transition edge.
   always_comb begin
      state_d   = state_q;
      cmd_d     = CMD_NOP;
      addr_d    = '0;
      done_d    = 1'b0;
      ready_d   = 1'b0;
      accept    = 1'b0;
      cnt_load  = 1'b0;
      cnt_value = '0;
      if (En) begin
         case (state_q)
            ST_IDLE: begin
               if (ReqValid && ready_q) begin
                  accept   = 1'b1;
                  cnt_load = 1'b1;
                  if (row_hit) begin
                     state_d   = ST_RW;
                     cmd_d     = ReqWe ? CMD_WRITE : CMD_READ;
                     addr_d    = SDADDR_W'(req_col);
                     cnt_value = rw_load(ReqWe, tlat, tburst, twait);
                  end else begin
                     state_d   = ST_PRE;
                     cmd_d     = CMD_PRECHARGE;
                     cnt_value = wait_load(tpre);
                  end
               end
            end
            ST_PRE, ST_PRE_WAIT: begin
               if (cnt_zero) begin
                  state_d   = ST_ACT;
                  cmd_d     = CMD_ACTIVATE;
                  addr_d    = SDADDR_W'(row_q);
                  cnt_load  = 1'b1;
                  cnt_value = wait_load(tcas);
               end else begin
                  state_d = ST_PRE_WAIT;
               end
            end
            ST_ACT, ST_ACT_WAIT: begin
               if (cnt_zero) begin
                  state_d   = ST_RW;
                  cmd_d     = we_q ? CMD_WRITE : CMD_READ;
                  addr_d    = SDADDR_W'(col_q);
                  cnt_load  = 1'b1;
                  cnt_value = rw_load(we_q, tlat, tburst, twait);
               end else begin
                  state_d = ST_ACT_WAIT;
               end
            end
            ST_RW, ST_RW_WAIT: begin
               if (cnt_zero) begin
                  state_d = ST_RECOVER;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RW_WAIT;
               end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         we_q  <= 1'b0;
         row_q <= '0;
         col_q <= '0;
      end else if (accept) begin
         we_q  <= ReqWe;
         row_q <= req_row;
         col_q <= req_col;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cmd_q   <= CMD_NOP;
         addr_q  <= '0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign CS        = cmd_q.cs;
   assign RAS       = cmd_q.ras;
   assign CAS       = cmd_q.cas;
   assign WeOut     = cmd_q.we;
   assign SdramAddr = addr_q;
   assign Done      = done_q;
   assign ReqReady  = ready_q;
   assign StateOut  = state_q;

endmodule

// File: tb/tb_sdram_cmd_gen.sv
// Scoreboard bench for sdram_cmd_gen: directed scenarios then randomized traffic.
module tb_sdram_cmd_gen;

   localparam logic [3:0] C_NOP = 4'b1111;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam int LIMIT = 3000;

   logic        Clk = 1'b0;
   logic        Rst, En, ReqValid, ReqWe;
   logic [15:0] ReqAddr;
   logic [7:0]  tpre, tcas, tburst, twait;
   logic [3:0]  tlat;
   logic        ReqReady, Done, CS, RAS, CAS, WeOut;
   logic [7:0]  SdramAddr;
   logic [2:0]  StateOut;

   sdram_cmd_gen dut (
      .Clk(Clk), .Rst(Rst), .En(En), .ReqValid(ReqValid), .ReqWe(ReqWe), .ReqAddr(ReqAddr),
      .tpre(tpre), .tcas(tcas), .tburst(tburst), .twait(twait), .tlat(tlat),
      .ReqReady(ReqReady), .Done(Done), .CS(CS), .RAS(RAS), .CAS(CAS), .WeOut(WeOut),
      .SdramAddr(SdramAddr), .StateOut(StateOut)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int         t;
      logic [3:0] cmd;
      logic [7:0] addr;
      logic       done;
      int         acc;
      int         lat;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0, n_bad = 0;
   int  cyc = 0, eidx = 0, ready_at = -1;
   bit  started = 0, last_en = 0, last_rst = 0, ready_m = 0, post_rst = 0;
   bit  acc_m;
   int  want_lat = 0;
   bit  tmo = 0, end_req = 0, rnd_en = 0;
`ifdef SDRAM_OPEN_ROW_EN
   logic [7:0] open_row_m;
   bit         open_valid_m = 0;
`endif

   function automatic int max1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   task automatic push(input int t, input logic [3:0] c, input logic [7:0] a, input logic d);
      ev_t e;
      e.t = t; e.cmd = c; e.addr = a; e.done = d; e.acc = cyc; e.lat = d ? want_lat : 0;
      exp_q.push_back(e);
   endtask

   // Reference model: time is counted in enabled clock edges; every delay is a plain sum.
   task automatic model_accept();
      int         a, d1, d2, d3;
      logic [7:0] row, col;
      logic [3:0] rw;
      bit         hit;
      a   = eidx;
      row = ReqAddr[15:8];
      col = ReqAddr[7:0];
      rw  = ReqWe ? C_WR : C_RD;
      d1  = max1(int'(tpre));
      d2  = max1(int'(tcas));
      d3  = (ReqWe ? 0 : int'(tlat)) + max1(int'(tburst)) + int'(twait);
      hit = 1'b0;
`ifdef SDRAM_OPEN_ROW_EN
      hit = open_valid_m && (open_row_m == row);
      open_row_m   = row;
      open_valid_m = 1'b1;
`endif
      if (hit) begin
         push(a, rw, col, 1'b0);
         push(a + d3, C_NOP, 8'h00, 1'b1);
         ready_at = a + d3 + 1;
      end else begin
         push(a, C_PRE, 8'h00, 1'b0);
         push(a + d1, C_ACT, row, 1'b0);
         push(a + d1 + d2, rw, col, 1'b0);
         push(a + d1 + d2 + d3, C_NOP, 8'h00, 1'b1);
         ready_at = a + d1 + d2 + d3 + 1;
      end
   endtask

   always @(posedge Clk) begin
      cyc++;
      started = 1'b1;
      if (Rst) begin
         exp_q.delete();
         ready_m  = 1'b0;
         post_rst = 1'b1;
         last_en  = 1'b0;
         last_rst = 1'b1;
         ready_at = -1;
`ifdef SDRAM_OPEN_ROW_EN
         open_valid_m = 1'b0;
`endif
      end else begin
         last_rst = 1'b0;
         last_en  = En;
         acc_m    = En && ReqValid && ready_m;
         if (En) eidx++;
         if (acc_m) model_accept();
         if (post_rst) begin
            ready_m  = 1'b1;
            post_rst = 1'b0;
         end else if (acc_m) begin
            ready_m = 1'b0;
         end else if (En && eidx == ready_at) begin
            ready_m = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
      end
   endtask

   logic [3:0] obs;
   ev_t        cur;

   // Monitor: pops the scoreboard whenever the DUT shows a command or Done.
   always @(negedge Clk) begin
      if (started) begin
         obs = {CS, RAS, CAS, WeOut};
         chk("ready", int'(ReqReady), int'(ready_m));
         if (last_rst) chk("reset_state", int'(StateOut), 0);
         if (obs != C_NOP || Done) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected at cycle %0d: got cmd=%b addr=%h done=%b, required no command",
                        cyc, obs, SdramAddr, Done);
            end else begin
               cur = exp_q.pop_front();
               n_cmp++;
               if (obs != cur.cmd || SdramAddr != cur.addr || Done != cur.done ||
                   !last_en || cur.t != eidx) begin
                  n_bad++;
                  $display("FAIL event at cycle %0d: got cmd=%b addr=%h done=%b slot=%0d en=%b, required cmd=%b addr=%h done=%b slot=%0d",
                           cyc, obs, SdramAddr, Done, eidx, last_en, cur.cmd, cur.addr, cur.done, cur.t);
               end
               if (cur.done && cur.lat > 0) chk("done_latency", cyc + 1 - cur.acc, cur.lat);
            end
         end else begin
            chk("idle_addr", int'(SdramAddr), 0);
            if (exp_q.size() > 0 && exp_q[0].t <= eidx) begin
               cur = exp_q.pop_front();
               n_cmp++; n_bad++;
               $display("FAIL missing at cycle %0d: got NOP, required cmd=%b addr=%h done=%b slot=%0d",
                        cyc, cur.cmd, cur.addr, cur.done, cur.t);
            end
         end
         if (end_req) begin
            chk("drain", exp_q.size(), 0);
            chk("timeout", int'(tmo), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
      if (rnd_en) En = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_accept();
      int n;
      n = 0;
      while (1) begin
         @(posedge Clk);
         if (ReqReady && En && !Rst) break;
         n++;
         if (n > LIMIT) begin
            tmo = 1'b1;
            $display("FAIL accept_timeout at cycle %0d", cyc);
            break;
         end
         #1;
         if (rnd_en) En = ($urandom_range(0, 3) != 0);
      end
      #1;
   endtask

   task automatic send(input logic we, input logic [15:0] a);
      ReqValid = 1'b1;
      ReqWe    = we;
      ReqAddr  = a;
      wait_accept();
      ReqValid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!ReqReady && n <= LIMIT);
      if (!ReqReady) begin
         tmo = 1'b1;
         $display("FAIL idle_timeout at cycle %0d", cyc);
      end
   endtask

   initial begin
      Rst = 1'b1; En = 1'b1; ReqValid = 1'b0; ReqWe = 1'b0; ReqAddr = '0;
      tpre = 8'd5; tcas = 8'd6; tlat = 4'd2; tburst = 8'd7; twait = 8'd1;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      step();

      want_lat = 20; send(1'b1, 16'h1234); wait_idle();
      want_lat = 22; send(1'b0, 16'hAB05); wait_idle();

      // Enable dropped for three edges while waiting after ACTIVATE.
      want_lat = 23; send(1'b1, 16'h2345);
      repeat (6) @(posedge Clk);
      #1 En = 1'b0;
      repeat (3) @(posedge Clk);
      #1 En = 1'b1;
      wait_idle();

      // Reset in the middle of an access.
      want_lat = 0; send(1'b1, 16'h3456);
      repeat (7) @(posedge Clk);
      #1 Rst = 1'b1;
      @(posedge Clk);
      #1 Rst = 1'b0;
      wait_idle();

      // ReqValid held high across a busy access.
      want_lat = 20;
      ReqValid = 1'b1; ReqWe = 1'b1; ReqAddr = 16'h4001;
      wait_accept();
      ReqAddr = 16'h5002;
      wait_accept();
      ReqValid = 1'b0;
      wait_idle();

      // Row reuse, then a row change.
      send(1'b1, 16'h1234); wait_idle();
`ifdef SDRAM_OPEN_ROW_EN
      want_lat = 9;
`else
      want_lat = 20;
`endif
      send(1'b1, 16'h1277); wait_idle();
      want_lat = 20; send(1'b1, 16'h1377); wait_idle();

      want_lat = 0;
      rnd_en   = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            tpre   = 8'($urandom_range(0, 40));
            tcas   = 8'($urandom_range(0, 40));
            tburst = 8'($urandom_range(0, 40));
            twait  = 8'($urandom_range(0, 40));
         end else begin
            tpre   = 8'($urandom_range(0, 4));
            tcas   = 8'($urandom_range(0, 4));
            tburst = 8'($urandom_range(0, 4));
            twait  = 8'($urandom_range(0, 3));
         end
         tlat = 4'($urandom_range(0, 15));
         send(1'($urandom_range(0, 1)), {8'(8'h10 + $urandom_range(0, 3)), 8'($urandom_range(0, 255))});
         if ($urandom_range(0, 19) == 0) begin
            repeat ($urandom_range(0, 12)) step();
            Rst = 1'b1;
            step();
            Rst = 1'b0;
         end
         wait_idle();
      end
      rnd_en = 1'b0;
      En     = 1'b1;
      repeat (30) step();
      end_req = 1'b1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sdram_cmd_gen.md
SDRAM_CMD_GEN -- requirements
Module: sdram_cmd_gen

Interface
REQ-001 The block SHALL have one clock, Clk, and a synchronous, active-high reset, Rst; there are no parameters.
REQ-002 The ports SHALL be as follows:
- Clk  in  1  clock
- Rst  in  1  synchronous reset, active-high
- En  in  1  advance enable; low freezes the block
- ReqValid  in  1  bus request valid
- ReqWe  in  1  1 = write, 0 = read
- ReqAddr  in  16  [15:8] row, [7:0] column
- tpre, tcas, tburst, twait  in  8 each  timing counts, in cycles
- tlat  in  4  read latency, in cycles
- ReqReady  out  1  request may be accepted
- Done  out  1  one-cycle completion pulse
- CS, RAS, CAS, WeOut  out  1 each  SDRAM command, active-low
- SdramAddr  out  8  row or column address
- StateOut  out  3  current state encoding

Function
REQ-003 Command encodings (CS,RAS,CAS,WeOut) SHALL be:
- NOP = 1111
- PRECHARGE = 0010
- ACTIVATE = 0011
- WRITE = 0100
- READ = 0101
REQ-004 A request SHALL be accepted on the rising edge where ReqValid, ReqReady and En are all 1; ReqWe and ReqAddr are latched on that edge.
REQ-005 ReqReady SHALL be 1 only in IDLE.
REQ-006 The state machine SHALL be IDLE(0) -> PRE(1) -> PRE_WAIT(2) -> ACT(3) -> ACT_WAIT(4) -> RW(5) -> RW_WAIT(6) -> RECOVER(7) -> IDLE.
REQ-007 All command and address outputs SHALL be registered.
REQ-008 PRECHARGE SHALL appear on the outputs for exactly one cycle, on the cycle after the accept edge.
REQ-009 ACTIVATE SHALL appear max(tpre,1) cycles after PRECHARGE, with SdramAddr = row.
REQ-010 WRITE or READ SHALL appear max(tcas,1) cycles after ACTIVATE, with SdramAddr = column.
REQ-011 Done SHALL pulse for one cycle at the following offset after the RW command:
- write: max(tburst,1) + twait cycles
- read: tlat + max(tburst,1) + twait cycles
REQ-012 ReqReady SHALL be 1 on the cycle after Done.
REQ-013 Every command SHALL last exactly one cycle; NOP and SdramAddr = 0 SHALL be driven in all other cycles.
REQ-014 Wait arithmetic SHALL be unsigned, using a 10-bit counter; the maximum sum of 4+8+8 bits does not overflow.
REQ-015 With En=0, state and counter SHALL hold and outputs SHALL be NOP with Done=0. A pending command SHALL be issued on the first cycle after En returns to 1.
REQ-016 ReqValid asserted while not in IDLE SHALL be ignored; the request is not latched.
REQ-017 Timing inputs SHALL be sampled on entry to each wait state, so changes mid-wait take effect only at the next wait.

Reset
REQ-018 While Rst=1, regardless of En, the outputs SHALL be:
- state = IDLE
- counter = 0
- CS, RAS, CAS, WeOut = NOP (1111)
- SdramAddr = 0
- Done = 0
- ReqReady = 0
REQ-019 ReqReady SHALL be 1 on the first cycle after Rst deasserts.
REQ-020 Rst asserted mid-operation SHALL abort the access with no further command issued and no Done pulse.

Configuration
REQ-021 The macro SDRAM_OPEN_ROW_EN, when defined, SHALL enable open-row mode with this behaviour:
- No precharge after an access; the last row is held in a register with a valid bit.
- A request whose row matches the open row SHALL go IDLE -> RW, with RW appearing on the cycle after accept.
- A request with a row miss SHALL take the full PRE/ACT sequence.
- Rst SHALL clear the valid bit.
REQ-022 Without SDRAM_OPEN_ROW_EN, every access SHALL take the full PRE/ACT sequence and no row register SHALL exist.

Structure
REQ-023 The shared package sdram_pkg SHALL hold:
- command encodings (REQ-003)
- state encodings (REQ-006)
- address and field widths
REQ-024 One sub-module, sdram_wait_counter, SHALL be used. It is a loadable 10-bit down-counter with En and a zero flag, and it provides all waits.

Verification
REQ-025 The bench SHALL use tpre=5, tcas=6, tlat=2, tburst=7, twait=1 and cover these scenarios:
- Write at 0x1234, accepted at edge k: PRE at k+1, ACT at k+6 with SdramAddr=0x12, WRITE at k+12 with SdramAddr=0x34, Done at k+20, ReqReady at k+21.
- Read at 0xAB05: READ at k+12 with SdramAddr=0x05; Done at k+22.
- En low for 3 cycles during ACT_WAIT: WRITE at k+15 and Done at k+23; NOP on the outputs while En is low.
- Rst pulsed at k+8: NOP, Done=0 and ReqReady=0 during reset; ReqReady=1 on the cycle after Rst falls; no WRITE issued.
- ReqValid held high during a busy access: the second request is accepted only in IDLE, and only one PRE is issued per access.
- SDRAM_OPEN_ROW_EN defined: a second write to 0x1277 gives WRITE at k+1 and Done at k+9; a write to 0x1377 gives the full sequence.
